// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests and buffers
// returned {pc, instr} pairs for the decoder. Define FETCH_PERF_EN to add perf counters.
module instr_fetch_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_en,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             valid_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] instr_out,
    output logic [1:0]       fetch_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall
`endif
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] fpc_q, fpc_d;
    logic [WIDTH-1:0] rpc_q, rpc_d;
    logic [CW-1:0]    outst_q, outst_d;
    logic [CW-1:0]    disc_q, disc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] fifo_pc_mem    [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_instr_mem [FIFO_DEPTH];

    logic             valid, pop, resp, push, grant, credit;
    logic [CW:0]      occupancy;
    logic [WIDTH-1:0] target_pc;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    always_comb begin
        target_pc = {redirect_pc[WIDTH-1:2], 2'b00};
        valid     = (cnt_q != '0);
        pop       = valid && pc_en && !redirect;
        // Responses with nothing outstanding are leftovers from before a reset.
        resp      = imem_rvalid && (outst_q != '0);
        push      = resp && (disc_q == '0) && !redirect;
        // A pop this cycle frees a slot by the time the new response can land.
        occupancy = {1'b0, outst_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
        credit    = (occupancy < DEPTH_W);
        imem_req  = (state_q == ST_RUN) && credit && !redirect && !rst;
        grant     = imem_req && imem_gnt;

        state_d  = state_q;
        fpc_d    = fpc_q;
        rpc_d    = rpc_q;
        disc_d   = disc_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        outst_d  = outst_q + CW'(grant) - CW'(resp);

        if (redirect) begin
            fpc_d    = target_pc;
            rpc_d    = target_pc;
            disc_d   = outst_q - CW'(resp);
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = (disc_d != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (grant) fpc_d = fpc_q + WIDTH'(4);
            if (push) begin
                rpc_d    = rpc_q + WIDTH'(4);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            if (resp && (disc_q != '0)) disc_d = disc_q - CW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   if (!credit) state_d = ST_FULL;
                ST_FULL:  if (pop) state_d = ST_RUN;
                ST_DRAIN: if (disc_d == '0) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            fpc_q    <= RESET_PC;
            rpc_q    <= RESET_PC;
            outst_q  <= '0;
            disc_q   <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            rpc_q    <= rpc_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            assert (!(push && !pop && (cnt_q == CW'(FIFO_DEPTH))));
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_mem[wr_ptr_q]    <= rpc_q;
            fifo_instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_addr   = fpc_q;
    assign valid_out   = valid;
    assign pc_out      = valid ? fifo_pc_mem[rd_ptr_q] : '0;
    assign instr_out   = valid ? fifo_instr_mem[rd_ptr_q] : NOP;
    assign fetch_state = state_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(push);
        perf_stall_d   = perf_stall_q + 32'(!valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, checked against an
// in-order memory model and the expected sequential PC stream.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, pc_en, redirect, imem_req, imem_gnt, imem_rvalid, valid_out;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, pc_out, instr_out;
    logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .valid_out(valid_out),
        .pc_out(pc_out), .instr_out(instr_out), .fetch_state(fetch_state)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = -1;
    int          pops = 0;
    int          pushes = 0;
    logic [31:0] exp_pc, exp_fpc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic        s_valid, s_req, s_rvalid;
    logic [31:0] s_pc, s_instr, s_addr;
    logic [1:0]  s_state;
    logic        popped;
    logic [31:0] popped_pc;
    logic        prev_redirect = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive the memory response, sample mid-cycle, update the model.
    task automatic cycle();
        int d;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        s_valid = valid_out; s_req = imem_req; s_rvalid = imem_rvalid;
        s_pc = pc_out; s_instr = instr_out; s_addr = imem_addr; s_state = fetch_state;
        popped = 1'b0;
        if (prev_redirect) chk("valid_after_redirect", 32'(valid_out), 32'd0);
        if (prev_stall && !redirect) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        if (!valid_out) begin
            chk("instr_when_empty", instr_out, NOP);
            chk("pc_when_empty", pc_out, 32'd0);
        end
        if (redirect) begin
            chk("no_req_on_redirect", 32'(imem_req), 32'd0);
            exp_pc  = {redirect_pc[31:2], 2'b00};
            exp_fpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (valid_out && pc_en) begin
                chk("pop_pc", pc_out, exp_pc);
                chk("pop_instr", instr_out, mem_word(exp_pc));
                popped = 1'b1;
                popped_pc = pc_out;
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (imem_req && imem_gnt) begin
                chk("req_addr", imem_addr, exp_fpc);
                exp_fpc = exp_fpc + 32'd4;
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend_addr.push_back(imem_addr);
                pend_due.push_back(d);
            end
        end
        if (imem_rvalid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        prev_redirect = redirect;
        prev_stall    = imem_req && !imem_gnt && !redirect;
        prev_addr     = imem_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] seq [3];
        int          n;
        logic        found, seen_req;
        int          start_pops;

        rst = 1'b1; pc_en = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_state", 32'(fetch_state), 32'd0);

        // Scenario 1: full throughput, one-cycle memory latency.
        rst = 1'b0; imem_gnt = 1'b1; pc_en = 1'b1; lat = 1;
        exp_pc = 32'd0; exp_fpc = 32'd0; cyc = 0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk("t1_valid", 32'(s_valid), (i >= 3) ? 32'd1 : 32'd0);
            if (i >= 3) chk("t1_pc", s_pc, 32'(4 * (i - 3)));
            if (i == 0) chk("t1_idle_noreq", 32'(s_req), 32'd0);
            if (i == 1) chk("t1_run_state", 32'(s_state), 32'd1);
            if (s_rvalid) pushes++;
        end
`ifdef FETCH_PERF_EN
        chk("perf_stall", perf_stall, 32'd3);
        chk("perf_fetched", perf_fetched, 32'(pushes));
`endif

        // Scenario 2: decoder stalls, FIFO fills, fetch goes FULL.
        pc_en = 1'b0;
        held = 32'd0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 0) held = s_pc;
            else chk("t2_hold", s_pc, held);
        end
        chk("t2_state_full", 32'(s_state), 32'd3);
        chk("t2_req_off", 32'(s_req), 32'd0);
        chk("t2_head", s_pc, exp_pc);
        pc_en = 1'b1;
        cycle();
        cycle();
        chk("t2_state_run", 32'(s_state), 32'd1);

        // Scenario 3: redirect with two requests outstanding.
        lat = 5;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (pend_due.size() == 2 && pend_due[0] > cyc) found = 1'b1;
            else cycle();
        end
        chk("t3_setup", 32'(found), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        redirect = 1'b0; lat = 1;
        cycle();
        chk("t3_state_drain", 32'(s_state), 32'd2);
        chk("t3_req_off", 32'(s_req), 32'd0);
        found = 1'b0; seen_req = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle();
            if (s_req && !seen_req) begin
                chk("t3_first_addr", s_addr, 32'h0000_0100);
                seen_req = 1'b1;
            end
            if (popped) begin
                chk("t3_first_pc", popped_pc, 32'h0000_0100);
                found = 1'b1;
            end
        end
        chk("t3_popped", 32'(found), 32'd1);

        // Scenario 4: PC wraps past the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            cycle();
            if (popped) begin
                seq[n] = popped_pc;
                n++;
            end
        end
        chk("t4_count", 32'(n), 32'd3);
        chk("t4_pc0", seq[0], 32'hFFFF_FFF8);
        chk("t4_pc1", seq[1], 32'hFFFF_FFFC);
        chk("t4_pc2", seq[2], 32'h0000_0000);

        // Scenario 5: memory refuses grants; request held, FIFO drains.
        imem_gnt = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        chk("t5_req_held", 32'(s_req), 32'd1);
        chk("t5_valid_off", 32'(s_valid), 32'd0);
        chk("t5_instr_nop", s_instr, NOP);
        imem_gnt = 1'b1;
        for (int k = 0; k < 6; k++) cycle();

        // Random traffic against the model.
        start_pops = pops;
        for (int k = 0; k < 400; k++) begin
            pc_en       = ($urandom_range(9) < 7);
            imem_gnt    = ($urandom_range(9) < 7);
            lat         = 1 + int'($urandom_range(3));
            redirect    = ($urandom_range(31) == 0);
            redirect_pc = $urandom;
            cycle();
        end
        chk("rand_progress", 32'(pops > start_pops + 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
